exmem_wb_ctrl: RTL and testbench

Wishbone classic slave that initiates accesses on the single-port, byte-writable user-project RAM port (WE0/EN0/Di0/Do0/A0 style, 1-cycle registered read, Do0 forced to 0 when EN0 is low). It sits between the Caravel user Wishbone bus and the external-memory RAM. It inserts a programmable access delay to emulate slow external memory. It captures read data in the single cycle it is valid and returns it with a one-cycle ack.

---
 rtl/exmem_wb_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_exmem_wb_ctrl.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/exmem_wb_ctrl.sv
// -----------------------------------------------------------------------------
// exmem_wb_ctrl
// Wishbone classic slave that fronts a single-port, byte-writable RAM with a
// 1-cycle registered read port. Each accepted request waits DELAY cycles to
// emulate slow external memory. It then spends one cycle driving the RAM port
// and acknowledges in the following cycle. For reads, the RAM output is
// returned in that acknowledge cycle.
//
// Ports
//   CLK, RST_N             clock (rising edge), asynchronous active-low reset
//   wbs_cyc_i, wbs_stb_i   bus cycle / strobe
//   wbs_we_i, wbs_sel_i    write flag, byte lane enables
//   wbs_adr_i, wbs_dat_i   byte address (word = [N+1:2]), write data
//   wbs_ack_o, wbs_dat_o   one-cycle ack, read data (0 outside a read ack)
//   ram_en, ram_we         RAM enable, per-byte write enables
//   ram_di, ram_a          RAM write data, RAM word address
//   ram_do                 RAM read data (registered inside the RAM)
//   busy                   high whenever a transfer is in progress
// -----------------------------------------------------------------------------
module exmem_wb_ctrl #(
    parameter int         N       = 14,
    parameter int         DELAY   = 10,
    parameter logic [7:0] BASE_HI = 8'h38
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic          wbs_cyc_i,
    input  logic          wbs_stb_i,
    input  logic          wbs_we_i,
    input  logic [3:0]    wbs_sel_i,
    input  logic [31:0]   wbs_adr_i,
    input  logic [31:0]   wbs_dat_i,
    output logic          wbs_ack_o,
    output logic [31:0]   wbs_dat_o,
    output logic          ram_en,
    output logic [3:0]    ram_we,
    output logic [31:0]   ram_di,
    output logic [N-1:0]  ram_a,
    input  logic [31:0]   ram_do,
    output logic          busy
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_ACCESS = 2'd2,
        ST_ACK    = 2'd3
    } state_t;

    // Final WAIT count. The counter starts at 0 in the first WAIT cycle, so
    // WAIT lasts exactly DELAY cycles.
    localparam logic [7:0] CNT_LAST = 8'(DELAY - 1);

    state_t         state_r;
    state_t         state_nxt_s;
    logic [7:0]     cnt_r;
    logic           we_r;
    logic [3:0]     sel_r;
    logic [N-1:0]   adr_r;
    logic [31:0]    dat_r;
    logic           ram_en_r;
    logic           ram_en_nxt_s;
    logic [3:0]     ram_we_r;
    logic [3:0]     ram_we_nxt_s;
    logic           ack_r;
    logic           ack_nxt_s;
    logic           busy_r;
    logic           busy_nxt_s;
    logic           hold_s;
    logic           req_s;
    logic           unused_adr_s;

    // hold_s keeps a transfer alive during WAIT. req_s additionally requires the
    // address window to match before a new transfer is accepted.
    assign hold_s       = wbs_cyc_i & wbs_stb_i;
    assign req_s        = hold_s & (wbs_adr_i[31:24] == BASE_HI);
    assign unused_adr_s = ^{wbs_adr_i[23:N+2], wbs_adr_i[1:0]};

    // State register.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Capture the request on acceptance and run the WAIT counter.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt_r <= 8'd0;
            we_r  <= 1'b0;
            sel_r <= 4'h0;
            adr_r <= {N{1'b0}};
            dat_r <= 32'h0000_0000;
        end else if ((state_r == ST_IDLE) && req_s) begin
            cnt_r <= 8'd0;
            we_r  <= wbs_we_i;
            sel_r <= wbs_sel_i;
            adr_r <= wbs_adr_i[N+1:2];
            dat_r <= wbs_dat_i;
        end else if (state_r == ST_WAIT) begin
            cnt_r <= cnt_r + 8'd1;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Next-state logic. An abort is honoured only while waiting; once ACCESS
    // is entered, the transfer always completes.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (req_s) begin
                    state_nxt_s = ST_WAIT;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (!hold_s) begin
                    state_nxt_s = ST_IDLE;
                end else if (cnt_r == CNT_LAST) begin
                    state_nxt_s = ST_ACCESS;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            ST_ACCESS: state_nxt_s = ST_ACK;
            ST_ACK:    state_nxt_s = ST_IDLE;
            default:   state_nxt_s = ST_IDLE;
        endcase
    end

    // Output decode from the next state, so every strobe comes straight from a
    // flop during the cycle it belongs to.
    always_comb begin
        ram_en_nxt_s = 1'b0;
        ram_we_nxt_s = 4'h0;
        ack_nxt_s    = 1'b0;
        busy_nxt_s   = 1'b0;
        if (state_nxt_s == ST_ACCESS) begin
            ram_en_nxt_s = 1'b1;
            if (we_r) begin
                ram_we_nxt_s = sel_r;
            end else begin
                ram_we_nxt_s = 4'h0;
            end
        end else begin
            ram_en_nxt_s = 1'b0;
            ram_we_nxt_s = 4'h0;
        end
        if (state_nxt_s == ST_ACK) begin
            ack_nxt_s = 1'b1;
        end else begin
            ack_nxt_s = 1'b0;
        end
        if (state_nxt_s != ST_IDLE) begin
            busy_nxt_s = 1'b1;
        end else begin
            busy_nxt_s = 1'b0;
        end
    end

    // Output registers.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ram_en_r <= 1'b0;
            ram_we_r <= 4'h0;
            ack_r    <= 1'b0;
            busy_r   <= 1'b0;
        end else begin
            ram_en_r <= ram_en_nxt_s;
            ram_we_r <= ram_we_nxt_s;
            ack_r    <= ack_nxt_s;
            busy_r   <= busy_nxt_s;
        end
    end

    assign ram_en    = ram_en_r;
    assign ram_we    = ram_we_r;
    assign ram_a     = adr_r;
    assign ram_di    = dat_r;
    assign busy      = busy_r;
    assign wbs_ack_o = ack_r;
    // RAM read data is valid only in the ACK cycle (registered at the ACCESS
    // edge), so it is passed through here rather than captured again.
    assign wbs_dat_o = (ack_r && !we_r) ? ram_do : 32'h0000_0000;

endmodule

// File: tb/tb_exmem_wb_ctrl.sv
`timescale 1ns/1ps
module tb_exmem_wb_ctrl;

    localparam int N     = 14;
    localparam int DELAY = 10;
    localparam int LAT   = DELAY + 2;

    logic          CLK = 1'b0;
    logic          RST_N = 1'b0;
    logic          wbs_cyc_i = 1'b0;
    logic          wbs_stb_i = 1'b0;
    logic          wbs_we_i = 1'b0;
    logic [3:0]    wbs_sel_i = 4'h0;
    logic [31:0]   wbs_adr_i = 32'h0;
    logic [31:0]   wbs_dat_i = 32'h0;
    logic          wbs_ack_o;
    logic [31:0]   wbs_dat_o;
    logic          ram_en;
    logic [3:0]    ram_we;
    logic [31:0]   ram_di;
    logic [N-1:0]  ram_a;
    logic [31:0]   ram_do;
    logic          busy;

    always #5 CLK = ~CLK;

    exmem_wb_ctrl #(.N(N), .DELAY(DELAY), .BASE_HI(8'h38)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_we_i(wbs_we_i),
        .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
        .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
        .ram_en(ram_en), .ram_we(ram_we), .ram_di(ram_di), .ram_a(ram_a),
        .ram_do(ram_do), .busy(busy)
    );

    // Behavioural RAM: byte writes, registered read, output forced to 0 when not enabled.
    logic [31:0]   ram_mem [0:(1<<N)-1];
    logic          pre_en = 1'b0;
    logic [N-1:0]  pre_a = '0;
    logic [31:0]   pre_d = 32'h0;

    always @(posedge CLK) begin
        if (pre_en) ram_mem[pre_a] <= pre_d;
        if (ram_en) begin
            for (int b = 0; b < 4; b++)
                if (ram_we[b]) ram_mem[ram_a][8*b +: 8] <= ram_di[8*b +: 8];
            ram_do <= ram_mem[ram_a];
        end else begin
            ram_do <= 32'h0;
        end
    end

    // Reference memory contents as seen through the bus.
    logic [31:0] model_mem [0:(1<<N)-1];

    int checks = 0;
    int errors = 0;

    // Per-transfer observations.
    int          r_ack_cyc, r_ack_cnt, r_en_cyc, r_en_cnt;
    logic [N-1:0] r_a;
    logic [3:0]  r_we;
    logic [31:0] r_di, r_rdata;
    logic        r_double, r_busy_seen, r_leak;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_ack"},  32'(wbs_ack_o), 32'h0);
        check({tag, "_dat"},  wbs_dat_o,      32'h0);
        check({tag, "_en"},   32'(ram_en),    32'h0);
        check({tag, "_we"},   32'(ram_we),    32'h0);
        check({tag, "_di"},   ram_di,         32'h0);
        check({tag, "_a"},    32'(ram_a),     32'h0);
        check({tag, "_busy"}, 32'(busy),      32'h0);
    endtask

    task automatic preload(input logic [N-1:0] w, input logic [31:0] d);
        pre_en = 1'b1; pre_a = w; pre_d = d;
        @(posedge CLK); #1;
        pre_en = 1'b0;
        model_mem[w] = d;
    endtask

    // Present one request at the current cycle (cycle 0) and observe up to
    // 'limit' cycles. Returns in the cycle after the ack (request dropped there),
    // so a following call starts its cycle 0 back-to-back.
    task automatic run_xfer(input logic we, input logic [3:0] sel, input logic [31:0] adr,
                            input logic [31:0] dat, input int abort_at, input int rst_at,
                            input int limit);
        logic prev_ack;
        r_ack_cyc = -1; r_ack_cnt = 0; r_en_cyc = -1; r_en_cnt = 0;
        r_a = '0; r_we = 4'h0; r_di = 32'h0; r_rdata = 32'h0;
        r_double = 1'b0; r_busy_seen = 1'b0; r_leak = 1'b0; prev_ack = 1'b0;
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we;
        wbs_sel_i = sel; wbs_adr_i = adr; wbs_dat_i = dat;
        for (int c = 1; c <= limit; c++) begin
            @(posedge CLK); #1;
            if (c == abort_at) wbs_stb_i = 1'b0;
            if (c == rst_at) begin
                RST_N = 1'b0; wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
                #1;
                check_zero("mid_rst");
            end
            if (c == rst_at + 2) RST_N = 1'b1;
            if (busy) r_busy_seen = 1'b1;
            if (ram_en) begin
                r_en_cnt++;
                if (r_en_cyc < 0) begin
                    r_en_cyc = c; r_a = ram_a; r_we = ram_we; r_di = ram_di;
                end
            end
            if (wbs_ack_o) begin
                r_ack_cnt++;
                if (prev_ack) r_double = 1'b1;
                if (r_ack_cyc < 0) begin
                    r_ack_cyc = c; r_rdata = wbs_dat_o;
                end
            end else if (wbs_dat_o !== 32'h0) begin
                r_leak = 1'b1;
            end
            prev_ack = wbs_ack_o;
            if (r_ack_cyc >= 0 && c == r_ack_cyc + 1) break;
        end
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
    endtask

    task automatic do_write(input string tag, input logic [31:0] adr, input logic [31:0] dat,
                            input logic [3:0] sel);
        logic [N-1:0] w;
        w = adr[N+1:2];
        run_xfer(1'b1, sel, adr, dat, -1, -1, 40);
        check({tag, "_ack_cyc"}, 32'(r_ack_cyc), 32'(LAT));
        check({tag, "_en_cyc"},  32'(r_en_cyc),  32'(LAT - 1));
        check({tag, "_ram_a"},   32'(r_a),       32'(w));
        check({tag, "_ram_we"},  32'(r_we),      32'(sel));
        check({tag, "_ram_di"},  r_di,           dat);
        check({tag, "_acks"},    32'(r_ack_cnt), 32'd1);
        check({tag, "_wdat0"},   r_rdata,        32'h0);
        check({tag, "_leak"},    32'(r_leak),    32'h0);
        for (int b = 0; b < 4; b++)
            if (sel[b]) model_mem[w][8*b +: 8] = dat[8*b +: 8];
    endtask

    task automatic do_read(input string tag, input logic [31:0] adr);
        logic [N-1:0] w;
        w = adr[N+1:2];
        run_xfer(1'b0, 4'hF, adr, 32'h0, -1, -1, 40);
        check({tag, "_ack_cyc"}, 32'(r_ack_cyc), 32'(LAT));
        check({tag, "_ram_a"},   32'(r_a),       32'(w));
        check({tag, "_ram_we"},  32'(r_we),      32'h0);
        check({tag, "_ens"},     32'(r_en_cnt),  32'd1);
        check({tag, "_double"},  32'(r_double),  32'h0);
        check({tag, "_data"},    r_rdata,        model_mem[w]);
        check({tag, "_leak"},    32'(r_leak),    32'h0);
    endtask

    int          first_ack;
    logic [31:0] radr;
    logic [N-1:0] rword;
    logic [7:0]  rhi;

    initial begin
        // Reset state.
        repeat (3) @(posedge CLK);
        #1;
        check_zero("reset");
        for (int i = 0; i < 16; i++) preload(N'(i), 32'h0101_0101 * 32'(i) ^ 32'hA5A5_0000);
        RST_N = 1'b1;
        @(posedge CLK); #1;
        check_zero("idle");

        // Full write then read back.
        do_write("t1_wr", 32'h3800_0010, 32'hDEAD_BEEF, 4'hF);
        check("t1_wr_a4", 32'(r_a), 32'd4);
        do_read("t1_rd", 32'h3800_0010);
        check("t1_rd_val", r_rdata, 32'hDEAD_BEEF);

        // Partial byte write.
        preload(N'(4), 32'h1122_3344);
        do_write("t2_wr", 32'h3800_0010, 32'hAABB_CCDD, 4'b0101);
        do_read("t2_rd", 32'h3800_0010);
        check("t2_rd_val", r_rdata, 32'h11BB_33DD);

        // Abort during WAIT.
        preload(N'(8), 32'hCAFE_F00D);
        run_xfer(1'b1, 4'hF, 32'h3800_0020, 32'h1234_5678, 5, -1, 30);
        check("t3_acks", 32'(r_ack_cnt), 32'd0);
        check("t3_ens",  32'(r_en_cnt),  32'd0);
        check("t3_idle", 32'(busy),      32'd0);
        do_read("t3_rd", 32'h3800_0020);
        check("t3_rd_val", r_rdata, 32'hCAFE_F00D);

        // Address outside the window.
        run_xfer(1'b0, 4'hF, 32'h3000_0000, 32'h0, -1, -1, 50);
        check("t4_acks", 32'(r_ack_cnt),   32'd0);
        check("t4_ens",  32'(r_en_cnt),    32'd0);
        check("t4_busy", 32'(r_busy_seen), 32'd0);

        // Back-to-back reads.
        preload(N'(0), 32'h0BAD_F00D);
        preload(N'(1), 32'h7654_3210);
        do_read("t5_rd0", 32'h3800_0000);
        first_ack = r_ack_cyc;
        check("t5_ack0_abs", 32'(first_ack), 32'd12);
        do_read("t5_rd1", 32'h3800_0004);
        check("t5_ack1_abs", 32'(first_ack + 1 + r_ack_cyc), 32'd25);
        check("t5_rd1_val", r_rdata, 32'h7654_3210);

        // Reset mid-transfer.
        preload(N'(4), 32'h5A5A_5A5A);
        run_xfer(1'b1, 4'hF, 32'h3800_0010, 32'hFFFF_0000, -1, 6, 30);
        check("t6_acks", 32'(r_ack_cnt), 32'd0);
        check("t6_ens",  32'(r_en_cnt),  32'd0);
        check("t6_mem",  ram_mem[4],     32'h5A5A_5A5A);
        do_read("t6_rd", 32'h3800_0010);

        // Write with no byte lanes enabled.
        do_write("t7_wr", 32'h3800_0014, 32'hFFFF_FFFF, 4'h0);
        do_read("t7_rd", 32'h3800_0014);

        // Randomized traffic against the reference memory.
        for (int k = 0; k < 30; k++) begin
            rword = N'($urandom_range(0, 15));
            rhi   = ($urandom_range(0, 7) == 0) ? 8'h39 : 8'h38;
            radr  = {rhi, 8'($urandom), 16'h0};
            radr[N+1:2] = rword;
            radr[1:0]   = 2'($urandom);
            if (rhi != 8'h38) begin
                run_xfer(1'($urandom), 4'hF, radr, $urandom, -1, -1, 20);
                check("rnd_bad_acks", 32'(r_ack_cnt), 32'd0);
                check("rnd_bad_ens",  32'(r_en_cnt),  32'd0);
            end else if ($urandom_range(0, 1) == 1) begin
                do_write("rnd_wr", radr, $urandom, 4'($urandom));
            end else begin
                do_read("rnd_rd", radr);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
